unidade_controle: RTL

//   Multicycle control FSM for the 64-bit datapath (PC, memoriaIns, IR, registrador, ULA, memoria, Mux1, Mux2).

---
 rtl/uc_pkg.sv | 36 +++
 rtl/imm_gen.sv | 25 ++
 rtl/unidade_controle.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/uc_pkg.sv
// Shared definitions for the multicycle control unit: datapath widths,
// RV64I opcode/funct fields for the supported subset, and the state encoding.
package uc_pkg;

    localparam int XLEN_DEF   = 64;
    localparam int ILEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_OP    = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;

    localparam logic [2:0] F3_DWORD = 3'b011;
    localparam logic [2:0] F3_ADD   = 3'b000;

    localparam logic [6:0] F7_ADD   = 7'b0000000;
    localparam logic [6:0] F7_SUB   = 7'b0100000;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    typedef enum logic [2:0] {
        FETCH  = S_FETCH,
        DECODE = S_DECODE,
        EXEC   = S_EXEC,
        MEM    = S_MEM,
        WB     = S_WB,
        HALT   = S_HALT
    } state_t;

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: picks the S-type split field for stores and the
// I-type field for everything else, then sign-extends to the datapath width.
module imm_gen
    import uc_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int ILEN = ILEN_DEF
) (
    input  logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] imm
);

    logic [11:0] raw;

    // Select the 12-bit immediate field by format and sign-extend it
    always_comb begin
        if (instr[6:0] == OP_STORE) begin
            raw = {instr[31:25], instr[11:7]};
        end else begin
            raw = instr[31:20];
        end
        imm = {{(XLEN-12){raw[11]}}, raw};
    end

endmodule

// File: rtl/unidade_controle.sv
// Multicycle control FSM for the 64-bit datapath (ld, sd, add, sub, addi).
// Optional feature: define UC_INSTR_CNT_EN to add the instr_cnt output,
// a 32-bit wrapping count of cycles in which we_pc is asserted.
module unidade_controle
    import uc_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int ILEN   = ILEN_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [ILEN-1:0]   instr,
    output logic              we_pc,
    output logic              we_ir,
    output logic              we_reg,
    output logic              we_mem,
    output logic              ula_sub,
    output logic              sel_mux1,
    output logic              sel_mux2,
    output logic [REG_AW-1:0] ra,
    output logic [REG_AW-1:0] rb,
    output logic [REG_AW-1:0] rw,
    output logic [XLEN-1:0]   imm,
`ifdef UC_INSTR_CNT_EN
    output logic [31:0]       instr_cnt,
`endif
    output logic              halted
);

    state_t state;
    state_t state_n;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       is_ld;
    logic       is_sd;
    logic       is_r;
    logic       is_sub;
    logic       is_addi;
    logic       legal;
    logic       fetch_ir;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    assign ra = instr[19:15];
    assign rb = instr[24:20];
    assign rw = instr[11:7];

    imm_gen #(.XLEN(XLEN), .ILEN(ILEN)) u_imm_gen (
        .instr (instr),
        .imm   (imm)
    );

    // Classify the instruction held in IR into the supported subset
    always_comb begin
        is_ld   = (opcode == OP_LOAD)  && (f3 == F3_DWORD);
        is_sd   = (opcode == OP_STORE) && (f3 == F3_DWORD);
        is_r    = (opcode == OP_OP)    && (f3 == F3_ADD) &&
                  ((f7 == F7_ADD) || (f7 == F7_SUB));
        is_sub  = is_r && (f7 == F7_SUB);
        is_addi = (opcode == OP_IMM)   && (f3 == F3_ADD);
        legal   = is_ld || is_sd || is_r || is_addi;
    end

    // State register; reset forces FETCH immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and control outputs; selects stay constant from EXEC to the last step
    always_comb begin
        state_n  = state;
        fetch_ir = 1'b0;
        we_pc    = 1'b0;
        we_reg   = 1'b0;
        we_mem   = 1'b0;
        ula_sub  = 1'b0;
        sel_mux1 = 1'b0;
        sel_mux2 = 1'b0;
        halted   = 1'b0;
        case (state)
            FETCH: begin
                if (run) begin
                    fetch_ir = 1'b1;
                    state_n  = DECODE;
                end
            end
            DECODE: begin
                state_n = legal ? EXEC : HALT;
            end
            EXEC: begin
                sel_mux1 = is_r;
                ula_sub  = is_sub;
                sel_mux2 = ~is_ld;
                state_n  = (is_ld || is_sd) ? MEM : WB;
            end
            MEM: begin
                sel_mux1 = is_r;
                ula_sub  = is_sub;
                sel_mux2 = ~is_ld;
                if (is_sd) begin
                    we_mem  = 1'b1;
                    we_pc   = 1'b1;
                    state_n = FETCH;
                end else begin
                    state_n = WB;
                end
            end
            WB: begin
                sel_mux1 = is_r;
                ula_sub  = is_sub;
                sel_mux2 = ~is_ld;
                we_reg   = 1'b1;
                we_pc    = 1'b1;
                state_n  = FETCH;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_n = FETCH;
            end
        endcase
    end

    // While reset is held the FSM sits in FETCH; keep the IR load off too
    assign we_ir = fetch_ir & ~rst;

`ifdef UC_INSTR_CNT_EN
    logic [31:0] cnt;

    // Retired-instruction counter, one step per PC update, wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 32'd0;
        end else if (we_pc) begin
            cnt <= cnt + 32'd1;
        end
    end

    assign instr_cnt = cnt;
`endif

endmodule
